edf_scheduler: RTL and testbench

Earliest-deadline-first queue scheduler for the MemorEDF memory-request path. Sits between the per-core request queues and the shared memory port, alongside the budget regulator. Each queue gets a programmable period. The block tracks a per-queue countdown to the queue's next deadline and offers the non-empty queue with the nearest deadline through a valid/ready handshake. It also flags deadline misses.

---
 rtl/memoredf_pkg.sv | 23 ++
 rtl/edf_argmin.sv | 53 +++++
 rtl/edf_scheduler.sv | 133 +++++++++++++
 tb/tb_edf_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/memoredf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memoredf_pkg
//  Description : Shared types and constants for the MemorEDF request path
//                (EDF scheduler and budget regulator).
//  Revision    : 1.0 - initial release
// ============================================================================
package memoredf_pkg;

    localparam int DEFAULT_NUMBER_OF_QUEUES = 4;
    localparam int DEFAULT_REGISTER_SIZE    = 8;
    localparam int ID_WIDTH                 = $clog2(DEFAULT_NUMBER_OF_QUEUES);

    typedef logic [ID_WIDTH-1:0]              queue_id_t;
    typedef logic [DEFAULT_REGISTER_SIZE-1:0] countdown_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage : memoredf_pkg
`default_nettype wire

// File: rtl/edf_argmin.sv
`default_nettype none
// ============================================================================
//  Module      : edf_argmin
//  Description : Combinational minimum-search tree over the eligible queues.
//                Returns the index of the smallest countdown, lowest index
//                winning ties, plus a flag saying any queue was eligible.
//  Revision    : 1.0 - initial release
// ============================================================================
module edf_argmin #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 8
) (
    input  logic [NUMBER_OF_QUEUES-1:0]         eligible,
    input  logic [REGISTER_SIZE-1:0]            remaining [NUMBER_OF_QUEUES],
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0] winner,
    output logic                                any_eligible
);

    localparam int c_ID_WIDTH = $clog2(NUMBER_OF_QUEUES);
    localparam int c_NODES    = 2 * NUMBER_OF_QUEUES - 1;

    // Heap-ordered tree: node k has children 2k+1 (lower indices) and 2k+2.
    // Leaves sit at NUMBER_OF_QUEUES-1 .. c_NODES-1 in queue order.
    logic                     w_node_vld [c_NODES];
    logic [REGISTER_SIZE-1:0] w_node_val [c_NODES];
    logic [c_ID_WIDTH-1:0]    w_node_idx [c_NODES];

    // Fill leaves, then reduce pairwise up to the root; the left child wins ties.
    always_comb begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            w_node_vld[NUMBER_OF_QUEUES-1+i] = eligible[i];
            w_node_val[NUMBER_OF_QUEUES-1+i] = remaining[i];
            w_node_idx[NUMBER_OF_QUEUES-1+i] = c_ID_WIDTH'(i);
        end
        for (int k = NUMBER_OF_QUEUES - 2; k >= 0; k--) begin
            if (w_node_vld[2*k+1] &&
                (!w_node_vld[2*k+2] || (w_node_val[2*k+1] <= w_node_val[2*k+2]))) begin
                w_node_vld[k] = 1'b1;
                w_node_val[k] = w_node_val[2*k+1];
                w_node_idx[k] = w_node_idx[2*k+1];
            end else begin
                w_node_vld[k] = w_node_vld[2*k+2];
                w_node_val[k] = w_node_val[2*k+2];
                w_node_idx[k] = w_node_idx[2*k+2];
            end
        end
    end

    assign winner       = w_node_idx[0];
    assign any_eligible = w_node_vld[0];

endmodule : edf_argmin
`default_nettype wire

// File: rtl/edf_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : edf_scheduler
//  Description : Earliest-deadline-first queue scheduler. Keeps a countdown to
//                each queue's next deadline, offers the non-empty queue with
//                the nearest deadline over valid/ready, and pulses a per-queue
//                miss flag when a pending deadline expires.
//  Revision    : 1.0 - initial release
// ============================================================================
module edf_scheduler #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int REGISTER_SIZE    = 8
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] periods,
    input  logic [NUMBER_OF_QUEUES-1:0]                   empty,
    input  logic                                          ready,
    output logic                                          valid,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]           selection,
    output logic [NUMBER_OF_QUEUES-1:0]                   miss
);

    import memoredf_pkg::*;

    localparam int c_ID_WIDTH = $clog2(NUMBER_OF_QUEUES);

    logic [REGISTER_SIZE-1:0]    r_remaining [NUMBER_OF_QUEUES];
    logic [NUMBER_OF_QUEUES-1:0] r_miss;
    logic                        r_valid;
    logic [c_ID_WIDTH-1:0]       r_selection;
    state_t                      r_state;

    state_t                      w_state_next;
    logic                        w_valid_next;
    logic [c_ID_WIDTH-1:0]       w_selection_next;
    logic [NUMBER_OF_QUEUES-1:0] w_eligible;
    logic [NUMBER_OF_QUEUES-1:0] w_grant_vec;
    logic [c_ID_WIDTH-1:0]       w_winner;
    logic                        w_any_eligible;
    logic                        w_grant;

    assign w_grant = (r_state == OFFER) && ready;

    // Per-queue eligibility and one-hot grant decode.
    always_comb begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            w_eligible[i]  = !empty[i] && (periods[i] != '0);
            w_grant_vec[i] = w_grant && (r_selection == c_ID_WIDTH'(i));
        end
    end

    edf_argmin #(
        .NUMBER_OF_QUEUES (NUMBER_OF_QUEUES),
        .REGISTER_SIZE    (REGISTER_SIZE)
    ) u_argmin (
        .eligible     (w_eligible),
        .remaining    (r_remaining),
        .winner       (w_winner),
        .any_eligible (w_any_eligible)
    );

    // Deadline countdowns: reload on reset or grant, otherwise saturating decrement.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (reset || w_grant_vec[i]) begin
                r_remaining[i] <= periods[i];
            end else if (r_remaining[i] != '0) begin
                r_remaining[i] <= r_remaining[i] - REGISTER_SIZE'(1);
            end
        end
    end

    // Miss pulse on the 1 -> 0 step of a pending, ungranted queue; a countdown
    // parked at zero cannot retrigger it.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (reset) begin
                r_miss[i] <= 1'b0;
            end else begin
                r_miss[i] <= (r_remaining[i] == REGISTER_SIZE'(1)) && !empty[i] && !w_grant_vec[i];
            end
        end
    end

    // FSM state and registered offer outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_valid     <= 1'b0;
            r_selection <= '0;
        end else begin
            r_state     <= w_state_next;
            r_valid     <= w_valid_next;
            r_selection <= w_selection_next;
        end
    end

    // Next-state logic: latch the winner in IDLE; in OFFER a grant beats a withdraw.
    always_comb begin
        w_state_next     = r_state;
        w_valid_next     = r_valid;
        w_selection_next = r_selection;
        case (r_state)
            IDLE: begin
                if (w_any_eligible) begin
                    w_state_next     = OFFER;
                    w_valid_next     = 1'b1;
                    w_selection_next = w_winner;
                end
            end
            OFFER: begin
                if (ready) begin
                    w_state_next = IDLE;
                    w_valid_next = 1'b0;
                end else if (empty[r_selection] || (periods[r_selection] == '0)) begin
                    w_state_next = IDLE;
                    w_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_valid_next = 1'b0;
            end
        endcase
    end

    assign valid     = r_valid;
    assign selection = r_selection;
    assign miss      = r_miss;

endmodule : edf_scheduler
`default_nettype wire

// File: tb/tb_edf_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edf_scheduler
//  Description : Self-checking bench for edf_scheduler with a behavioural
//                reference model and an expected-output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edf_scheduler;

    localparam int NQ = 4;
    localparam int RS = 8;

    typedef logic [NQ-1:0][RS-1:0] per_t;

    typedef struct {
        bit          valid;
        int          sel;
        bit [NQ-1:0] miss;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    per_t          periods;
    logic [NQ-1:0] empty;
    logic          ready;
    logic          valid;
    logic [1:0]    selection;
    logic [NQ-1:0] miss;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model state: what the scheduler should hold after the last edge.
    int m_rem[NQ];
    bit m_valid;
    int m_sel;

    always #5 clock = ~clock;

    edf_scheduler #(
        .NUMBER_OF_QUEUES (NQ),
        .REGISTER_SIZE    (RS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .periods   (periods),
        .empty     (empty),
        .ready     (ready),
        .valid     (valid),
        .selection (selection),
        .miss      (miss)
    );

    function automatic per_t mkp(input int a, input int b, input int c, input int d);
        per_t p;
        p[0] = RS'(a);
        p[1] = RS'(b);
        p[2] = RS'(c);
        p[3] = RS'(d);
        return p;
    endfunction

    // Apply one cycle of inputs, predict the outputs after the coming edge.
    task automatic step(input bit r, input per_t p, input logic [NQ-1:0] e, input bit rd);
        exp_t x;
        int   nrem[NQ];
        int   best;
        bit   grant;
        reset   = r;
        periods = p;
        empty   = e;
        ready   = rd;
        x.miss  = '0;
        if (r) begin
            for (int i = 0; i < NQ; i++) nrem[i] = int'(p[i]);
            x.valid = 1'b0;
            m_sel   = 0;
        end else begin
            grant = m_valid && rd;
            for (int i = 0; i < NQ; i++) begin
                if (grant && m_sel == i) nrem[i] = int'(p[i]);
                else nrem[i] = (m_rem[i] > 0) ? m_rem[i] - 1 : 0;
                x.miss[i] = (m_rem[i] == 1) && !e[i] && !(grant && m_sel == i);
            end
            if (!m_valid) begin
                best = -1;
                for (int i = 0; i < NQ; i++)
                    if (!e[i] && p[i] != 0 && (best < 0 || m_rem[i] < m_rem[best])) best = i;
                x.valid = (best >= 0);
                if (best >= 0) m_sel = best;
            end else begin
                x.valid = !(rd || e[m_sel] || p[m_sel] == 0);
            end
        end
        x.sel   = m_sel;
        m_valid = x.valid;
        m_rem   = nrem;
        exp_q.push_back(x);
        @(negedge clock);
    endtask

    // Monitor: compare each observed cycle against the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checks++;
                if (valid !== x.valid) begin
                    errors++;
                    $display("FAIL valid t=%0t got %b want %b", $time, valid, x.valid);
                end
                if (x.valid) begin
                    checks++;
                    if (selection !== 2'(x.sel)) begin
                        errors++;
                        $display("FAIL selection t=%0t got %0d want %0d", $time, selection, x.sel);
                    end
                end
                checks++;
                if (miss !== NQ'(x.miss)) begin
                    errors++;
                    $display("FAIL miss t=%0t got %b want %b", $time, miss, x.miss);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        per_t p;
        // Idle after reset, all empty.
        p = mkp(10, 20, 30, 40);
        repeat (2) step(1, p, 4'hF, 0);
        repeat (6) step(0, p, 4'hF, 0);
        // Queues 1 and 3 pending, queue 3 has the shorter period.
        p = mkp(0, 20, 0, 8);
        repeat (2) step(1, p, 4'hF, 0);
        repeat (14) step(0, p, 4'b0101, 1);
        // Tie between queues 0 and 2, held offer.
        p = mkp(9, 0, 9, 0);
        step(1, p, 4'hF, 0);
        repeat (6) step(0, p, 4'b1010, 0);
        repeat (4) step(0, p, 4'b1010, 1);
        // Withdraw of queue 2, then ready and empty together.
        p = mkp(0, 0, 5, 0);
        step(1, p, 4'hF, 0);
        repeat (2) step(0, p, 4'b1011, 0);
        repeat (2) step(0, p, 4'hF, 0);
        repeat (2) step(0, p, 4'b1011, 0);
        step(0, p, 4'hF, 1);
        repeat (3) step(0, p, 4'b1011, 0);
        // Deadline miss on queue 1 while queue 0 holds the offer.
        p = mkp(6, 3, 0, 0);
        step(1, p, 4'hF, 0);
        step(0, p, 4'b1110, 0);
        repeat (8) step(0, p, 4'b1100, 0);
        // Reset while offering, then queue 1 disabled.
        step(1, p, 4'b1100, 0);
        p = mkp(6, 0, 0, 0);
        step(1, p, 4'b1100, 0);
        repeat (10) step(0, p, 4'b1100, 1'($urandom_range(0, 1)));
        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            if (n % 25 == 0) begin
                for (int i = 0; i < NQ; i++) begin
                    case ($urandom_range(0, 5))
                        0: p[i] = 8'd0;
                        1: p[i] = 8'd1;
                        2: p[i] = 8'd255;
                        default: p[i] = 8'($urandom_range(2, 12));
                    endcase
                end
            end
            step(($urandom_range(0, 60) == 0), p, 4'($urandom), ($urandom_range(0, 2) != 0));
        end
        @(posedge clock);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_edf_scheduler
`default_nettype wire
